// File: rtl/fft32_core.sv
// fft32_core: 32-point radix-2 DIT FFT, in place over a register file.
// Ports: clk, rst_n, in_valid, din_r/din_i (12b in), out_valid, dout_r/dout_i (16b out).
module fft32_core #(
   parameter int FFT_SIZE  = 32,
   parameter int IN_WIDTH  = 12,
   parameter int OUT_WIDTH = 16,
   parameter int TW_WIDTH  = 12
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   input  logic [IN_WIDTH-1:0]  din_r,
   input  logic [IN_WIDTH-1:0]  din_i,
   output logic                 out_valid,
   output logic [OUT_WIDTH-1:0] dout_r,
   output logic [OUT_WIDTH-1:0] dout_i
);

   // Two guard bits below the input LSB, five bits of growth, two spare.
   localparam int GB   = 2;
   localparam int DW   = IN_WIDTH + GB + 5 + 2;
   localparam int DX   = DW + 1;
   localparam int DP   = DW + TW_WIDTH + 1;
   localparam int FRAC = TW_WIDTH - 2;
   localparam int NB   = 4;
   localparam int CPS  = (FFT_SIZE / 2) / NB;
   localparam int CLST = 5 * CPS - 1;
   localparam int OMAX = 2 ** (OUT_WIDTH - 1) - 1;
   localparam int OMIN = -(2 ** (OUT_WIDTH - 1));

   // W^m = cos - j*sin, Q1.10.
   localparam int COS_T [16] = '{
      1024, 1004, 946, 851, 724, 569, 392, 200,
      0, -200, -392, -569, -724, -851, -946, -1004
   };
   localparam int NSIN_T [16] = '{
      0, -200, -392, -569, -724, -851, -946, -1004,
      -1024, -1004, -946, -851, -724, -569, -392, -200
   };

   typedef enum logic [1:0] {
      IDLE, LOAD, COMPUTE, OUTPUT
   } state_t;

   state_t st;
   logic [4:0] cnt;

   logic signed [DW-1:0] mem_r [FFT_SIZE];
   logic signed [DW-1:0] mem_i [FFT_SIZE];

   logic [4:0]           top_a [NB];
   logic [4:0]           bot_a [NB];
   logic signed [DW-1:0] yt_r  [NB];
   logic signed [DW-1:0] yt_i  [NB];
   logic signed [DW-1:0] yb_r  [NB];
   logic signed [DW-1:0] yb_i  [NB];

   logic [2:0] stg;
   logic [1:0] cyc;
   logic       ld_en;

   assign stg   = cnt[4:2];
   assign cyc   = cnt[1:0];
   assign ld_en = in_valid && (st == IDLE || st == LOAD);

   function automatic logic [4:0] bitrev(input logic [4:0] a);
      return {a[0], a[1], a[2], a[3], a[4]};
   endfunction

   // Drop guard bits plus the overall halving, round half up, clamp.
   function automatic logic [OUT_WIDTH-1:0] scale_out(
      input logic signed [DW-1:0] v
   );
      logic signed [DX-1:0] s;
      s = (DX'(v) + DX'(1 << GB)) >>> (GB + 1);
      if (s > DX'(OMAX))
         return OUT_WIDTH'(OMAX);
      if (s < DX'(OMIN))
         return OUT_WIDTH'(OMIN);
      return OUT_WIDTH'(s);
   endfunction

   // NB butterflies per cycle; CPS cycles per stage, five stages.
   always_comb begin
      logic [4:0]             h, msk, b, pos, tp, bt;
      logic [3:0]             mw;
      logic signed [TW_WIDTH-1:0] wr, wi;
      logic signed [DW-1:0]   ar, ai, br, bi, tr, ti;
      logic signed [DP-1:0]   pr, pi;
      top_a = '{default: '0};
      bot_a = '{default: '0};
      yt_r  = '{default: '0};
      yt_i  = '{default: '0};
      yb_r  = '{default: '0};
      yb_i  = '{default: '0};
      for (int p = 0; p < NB; p++) begin
         h   = 5'd1 << stg;
         msk = h - 5'd1;
         b   = {1'b0, cyc, 2'(p)};
         pos = b & msk;
         tp  = ((b & ~msk) << 1) | pos;
         bt  = tp | h;
         mw  = 4'(pos << (3'd4 - stg));
         wr  = TW_WIDTH'(COS_T[mw]);
         wi  = TW_WIDTH'(NSIN_T[mw]);
         ar  = mem_r[tp];
         ai  = mem_i[tp];
         br  = mem_r[bt];
         bi  = mem_i[bt];
         pr  = DP'(br) * DP'(wr) - DP'(bi) * DP'(wi);
         pi  = DP'(br) * DP'(wi) + DP'(bi) * DP'(wr);
         pr  = pr + DP'(1 << (FRAC - 1));
         pi  = pi + DP'(1 << (FRAC - 1));
         tr  = DW'(pr >>> FRAC);
         ti  = DW'(pi >>> FRAC);
         top_a[p] = tp;
         bot_a[p] = bt;
         yt_r[p]  = ar + tr;
         yt_i[p]  = ai + ti;
         yb_r[p]  = ar - tr;
         yb_i[p]  = ai - ti;
      end
   end

   // Samples land at bit-reversed addresses so results read out in order.
   always_ff @(posedge clk) begin
      if (ld_en) begin
         mem_r[bitrev(cnt)] <= DW'($signed({din_r, 2'b00}));
         mem_i[bitrev(cnt)] <= DW'($signed({din_i, 2'b00}));
      end
      if (st == COMPUTE) begin
         for (int p = 0; p < NB; p++) begin
            mem_r[top_a[p]] <= yt_r[p];
            mem_i[top_a[p]] <= yt_i[p];
            mem_r[bot_a[p]] <= yb_r[p];
            mem_i[bot_a[p]] <= yb_i[p];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st        <= IDLE;
         cnt       <= '0;
         out_valid <= 1'b0;
         dout_r    <= '0;
         dout_i    <= '0;
      end else begin
         out_valid <= 1'b0;
         dout_r    <= '0;
         dout_i    <= '0;
         unique case (st)
            IDLE: begin
               if (in_valid) begin
                  cnt <= 5'd1;
                  st  <= LOAD;
               end
            end
            LOAD: begin
               if (in_valid) begin
                  cnt <= cnt + 5'd1;
                  if (cnt == 5'(FFT_SIZE - 1)) begin
                     cnt <= '0;
                     st  <= COMPUTE;
                  end
               end
            end
            COMPUTE: begin
               cnt <= cnt + 5'd1;
               if (cnt == 5'(CLST)) begin
                  cnt <= '0;
                  st  <= OUTPUT;
               end
            end
            OUTPUT: begin
               out_valid <= 1'b1;
               dout_r    <= scale_out(mem_r[cnt]);
               dout_i    <= scale_out(mem_i[cnt]);
               cnt       <= cnt + 5'd1;
               if (cnt == 5'(FFT_SIZE - 1)) begin
                  cnt <= '0;
                  st  <= IDLE;
               end
            end
            default: st <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fft32_core.sv
// tb_fft32_core: directed frames for fft32_core with in-bench golden values.
// Drives on negedge, samples on negedge; prints one TB_RESULT line.
module tb_fft32_core;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic [11:0] din_r;
   logic [11:0] din_i;
   logic        out_valid;
   logic [15:0] dout_r;
   logic [15:0] dout_i;

   int checks   = 0;
   int failures = 0;
   int xr [32];
   int xi [32];
   int yr [32];
   int yi [32];
   int gap_at   = -1;

   localparam real PI = 3.14159265358979323846;

   fft32_core dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .din_r     (din_r),
      .din_i     (din_i),
      .out_valid (out_valid),
      .dout_r    (dout_r),
      .dout_i    (dout_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got,
                      input int lo, input int hi);
      logic ok;
      ok = (got >= lo) && (got <= hi);
      checks++;
      assert (ok === 1'b1) else begin
         failures++;
         $error("FAIL %s got=%0d exp=%0d..%0d", tag, got, lo, hi);
      end
   endtask

   function automatic int rnd(input real v);
      int r;
      r = $rtoi($floor(v + 0.5));
      if (r > 32767) r = 32767;
      if (r < -32768) r = -32768;
      return r;
   endfunction

   task automatic fill(input int r, input int i);
      for (int n = 0; n < 32; n++) begin
         xr[n] = r;
         xi[n] = i;
      end
   endtask

   // Starts driving at the current negedge; returns at the negedge
   // where out_valid has just fallen.
   task automatic run_frame(input string tag);
      int lat, gaps, zbad;
      lat  = 0;
      gaps = 0;
      zbad = 0;
      for (int n = 0; n < 32; n++) begin
         if (n == gap_at) begin
            in_valid = 1'b0;
            repeat (3) @(negedge clk);
         end
         in_valid = 1'b1;
         din_r    = 12'(xr[n]);
         din_i    = 12'(xi[n]);
         @(negedge clk);
      end
      in_valid = 1'b0;
      din_r    = '0;
      din_i    = '0;
      while (out_valid !== 1'b1 && lat < 100) begin
         if (dout_r !== 16'd0 || dout_i !== 16'd0) zbad++;
         @(negedge clk);
         lat++;
      end
      chk({tag, "_lat"}, lat, 1, 68);
      chk({tag, "_idle0"}, zbad, 0, 0);
      if (lat >= 100) return;
      for (int k = 0; k < 32; k++) begin
         if (out_valid !== 1'b1) gaps++;
         yr[k] = int'($signed(dout_r));
         yi[k] = int'($signed(dout_i));
         @(negedge clk);
      end
      chk({tag, "_gaps"}, gaps, 0, 0);
      chk({tag, "_fall"}, int'(out_valid), 0, 0);
   endtask

   task automatic check_snr(input string tag);
      real gr, gi, a, sig, noi;
      int er, ei;
      sig = 0.0;
      noi = 0.0;
      for (int k = 0; k < 32; k++) begin
         gr = 0.0;
         gi = 0.0;
         for (int n = 0; n < 32; n++) begin
            a  = 2.0 * PI * real'((n * k) % 32) / 32.0;
            gr = gr + xr[n] * $cos(a) + xi[n] * $sin(a);
            gi = gi + xi[n] * $cos(a) - xr[n] * $sin(a);
         end
         er  = rnd(gr / 2.0);
         ei  = rnd(gi / 2.0);
         sig = sig + real'(er * er + ei * ei);
         noi = noi + real'((er - yr[k]) * (er - yr[k]))
                   + real'((ei - yi[k]) * (ei - yi[k]));
      end
      chk(tag, (sig >= 10000.0 * noi) ? 1 : 0, 1, 1);
   endtask

   initial begin
      int hi_cnt, er, ei;
      rst_n    = 1'b0;
      in_valid = 1'b0;
      din_r    = '0;
      din_i    = '0;
      repeat (3) @(negedge clk);
      chk("rst_ov", int'(out_valid), 0, 0);
      chk("rst_dr", int'(dout_r), 0, 0);
      chk("rst_di", int'(dout_i), 0, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Impulse: flat spectrum of 100.
      fill(0, 0);
      xr[0] = 200;
      run_frame("imp");
      for (int k = 0; k < 32; k++) begin
         chk($sformatf("imp_r%0d", k), yr[k], 100, 100);
         chk($sformatf("imp_i%0d", k), yi[k], 0, 0);
      end

      // DC with a mid-frame in_valid gap.
      fill(100, 0);
      gap_at = 16;
      run_frame("dc");
      gap_at = -1;
      chk("dc_r0", yr[0], 1600, 1600);
      chk("dc_i0", yi[0], 0, 0);
      for (int k = 1; k < 32; k++) begin
         chk($sformatf("dc_r%0d", k), yr[k], -1, 1);
         chk($sformatf("dc_i%0d", k), yi[k], -1, 1);
      end

      // Single tone in bin 1.
      for (int n = 0; n < 32; n++) begin
         xr[n] = rnd(1000.0 * $cos(2.0 * PI * n / 32.0));
         xi[n] = rnd(1000.0 * $sin(2.0 * PI * n / 32.0));
      end
      run_frame("tone");
      chk("tone_r1", yr[1], 15996, 16004);
      chk("tone_i1", yi[1], -4, 4);
      for (int k = 0; k < 32; k++) begin
         if (k != 1)
            chk($sformatf("tone_m%0d", k),
                yr[k] * yr[k] + yi[k] * yi[k], 0, 16);
      end

      // Full-scale positive and negative DC.
      fill(2047, 2047);
      run_frame("satp");
      chk("satp_r0", yr[0], 32752, 32752);
      chk("satp_i0", yi[0], 32752, 32752);
      for (int k = 1; k < 32; k++) begin
         chk($sformatf("satp_r%0d", k), yr[k], -1, 1);
         chk($sformatf("satp_i%0d", k), yi[k], -1, 1);
      end
      fill(-2048, -2048);
      run_frame("satn");
      chk("satn_r0", yr[0], -32768, -32768);
      chk("satn_i0", yi[0], -32768, -32768);

      // Delayed impulse, started right after the previous frame.
      fill(0, 0);
      xr[2] = 400;
      run_frame("b2b");
      for (int k = 0; k < 32; k++) begin
         er = rnd(200.0 * $cos(PI * k / 8.0));
         ei = rnd(-200.0 * $sin(PI * k / 8.0));
         chk($sformatf("b2b_r%0d", k), yr[k], er - 2, er + 2);
         chk($sformatf("b2b_i%0d", k), yi[k], ei - 2, ei + 2);
      end

      // Random frames with a reset pulse before each.
      for (int f = 0; f < 5; f++) begin
         rst_n = 1'b0;
         @(negedge clk);
         rst_n = 1'b1;
         @(negedge clk);
         for (int n = 0; n < 32; n++) begin
            xr[n] = int'($urandom_range(0, 4095)) - 2048;
            xi[n] = int'($urandom_range(0, 4095)) - 2048;
         end
         run_frame($sformatf("rnd%0d", f));
         check_snr($sformatf("rnd%0d_snr", f));
      end

      // Abort during LOAD: nothing may come out.
      for (int n = 0; n < 10; n++) begin
         in_valid = 1'b1;
         din_r    = 12'(300 + n);
         din_i    = 12'(n);
         @(negedge clk);
      end
      in_valid = 1'b0;
      rst_n    = 1'b0;
      @(negedge clk);
      rst_n  = 1'b1;
      hi_cnt = 0;
      repeat (80) begin
         @(negedge clk);
         if (out_valid !== 1'b0) hi_cnt++;
      end
      chk("abort_ov", hi_cnt, 0, 0);
      fill(0, 0);
      xr[0] = -300;
      xi[0] = 100;
      run_frame("post");
      for (int k = 0; k < 32; k++) begin
         chk($sformatf("post_r%0d", k), yr[k], -150, -150);
         chk($sformatf("post_i%0d", k), yi[k], 50, 50);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fft32_core.md
Name: fft32_core

Overview:
- 32-point complex radix-2 FFT for a streaming front end.
- Accepts one frame of 32 signed 12-bit complex samples on consecutive cycles while in_valid is high.
- Computes the DFT X[k] = sum x[n]·e^(-j2πnk/32).
- Streams 32 signed 16-bit complex results in natural order k=0..31, flagged by out_valid.

Parameters:
- FFT_SIZE, 32, points per frame (fixed; not required to work at other values).
- IN_WIDTH, 12, input sample width per component, signed two's complement.
- OUT_WIDTH, 16, output width per component, signed two's complement.
- TW_WIDTH, 12, twiddle width per component, signed, 10 fractional bits.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- in_valid  in  1  high for exactly 32 consecutive cycles per frame; each high cycle carries one sample.
- din_r  in  12  input real part x[n], n = 0..31 in arrival order.
- din_i  in  12  input imaginary part.
- out_valid  out  1  high for exactly 32 consecutive cycles per frame.
- dout_r  out  16  output real part.
- dout_i  out  16  output imaginary part.

Behaviour:
- Reset state:
  - While rst_n=0: out_valid=0, dout_r=0, dout_i=0, all counters and state cleared, FSM in IDLE.
  - Deasserting rst_n mid-frame aborts that frame; no partial output is produced.
- Input sampling: din_r/din_i are sampled on each rising edge where in_valid=1. The first sampled edge of a frame is n=0.
- FSM states and transitions:
  - IDLE -> LOAD on the first in_valid=1.
  - LOAD: count 32 samples, then -> COMPUTE.
  - COMPUTE: butterflies run (iterative in-place or pipelined SDF; implementer's choice) -> OUTPUT.
  - OUTPUT: 32 cycles -> IDLE.
- Input outside IDLE/LOAD: in_valid=1 in COMPUTE/OUTPUT is ignored.
- Short frame: if in_valid drops before 32 samples, the FSM holds in LOAD and waits for the remaining samples.
- Output timing:
  - out_valid rises no more than 68 clock cycles after the cycle in_valid falls.
  - Once high, out_valid stays high exactly 32 consecutive cycles with no gaps.
  - dout_r/dout_i are registered outputs.
  - The i-th valid cycle carries X[i] (natural order, bit-reversal undone internally).
  - While out_valid=0, dout_r=dout_i=0.
- Back-to-back frames: a new frame may start the cycle after out_valid falls, with no reset needed.
- Arithmetic and scaling:
  - dout = round(X[k]/2), i.e. full DFT gain of 32 with one bit of right shift overall.
  - Internal widths grow one bit per stage; keep at least 2 guard fractional bits through the stages.
  - Twiddle products are rounded to nearest, not truncated.
  - Final result saturates to [-32768, 32767] per component; it never wraps.
- Twiddles: W^m = cos(2πm/32) - j·sin(2πm/32), m = 0..15, stored as a constant ROM in Q1.10. W^0 uses +1.0 (1024).
- Accuracy: over any frame, sum|gold-dout|² must satisfy signal energy / noise energy ≥ 10000 (SNR ≥ 40 dB). Gold is the double-precision DFT/2 rounded to integer.

Test Plan:
- Impulse: x[0]=200+0j, others 0 -> all 32 outputs dout_r=100, dout_i=0; out_valid rises ≤68 cycles after in_valid falls.
- DC: x[n]=100+0j for all n -> X[0]=1600+0j, X[1..31]=0 (±1 LSB).
- Tone: x[n]=1000·e^(j2πn/32), components rounded -> X[1]≈16000+0j (±4 LSB), all other bins |dout|≤4.
- Saturation: x[n]=2047+2047j for all n -> X[0]=32752+32752j, other bins ≈0; then x[n]=-2048-2048j for all n -> X[0]=-32768-32768j.
- Random five frames: uniform random 12-bit samples, rst_n pulse between frames -> each frame SNR ≥ 40 dB vs golden; out_valid exactly 32 contiguous cycles.
- Back-to-back and abort:
  - Frame 2 starts the cycle after out_valid falls, no reset -> correct results.
  - rst_n pulled low during LOAD -> out_valid stays 0, and the next full frame is correct.
